prng_seq_checker: RTL

//  Receive side of the on-chip PRNG: checks a serial bit stream produced by the 16-bit LFSR
//  (polynomial taps 15,14,12,3; shift left, feedback into bit 0).

---
 rtl/prng_pkg.sv | 22 ++
 rtl/prng_err_counter.sv | 45 ++++
 rtl/prng_seq_checker.sv | 131 +++++++++++++
 3 files changed

// File: rtl/prng_pkg.sv
// Shared definitions for the on-chip 16-bit PRNG (generator and checker).
package prng_pkg;

  localparam int LFSR_W = 16;

  // Feedback taps at bits 15, 14, 12 and 3.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hD008;

  // Width of the acquisition bit counter (counts up to 16 received bits).
  localparam int ACQ_W = 5;

  typedef enum logic [0:0] {
    ST_ACQUIRE = 1'b0,
    ST_LOCKED  = 1'b1
  } state_e;

  // Next bit of the LFSR for a given state (shift left, feedback into bit 0).
  function automatic logic lfsr_fb(input logic [LFSR_W-1:0] s);
    return ^(s & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/prng_err_counter.sv
// Saturating mismatch counter. A clear that coincides with a new mismatch
// leaves the count at one so that error is not lost.
module prng_err_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear has priority over increment, increment stops at all-ones.
  always_comb begin
    count_d = count_q;
    if (clr_i && inc_i) begin
      count_d = CNT_ONE;
    end else if (clr_i) begin
      count_d = CNT_ZERO;
    end else if (inc_i && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= CNT_ZERO;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/prng_seq_checker.sv
// Receive-side PRNG checker. Loads its LFSR state from the first 16 received
// bits, then predicts every following bit and reports mismatches. Predicted
// bits (not received bits) are shifted in while locked, so a single corrupt
// bit is counted once and does not disturb later predictions.
module prng_seq_checker
  import prng_pkg::*;
#(
  parameter int LOSS_THRESH = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [3:0]       THRESH   = 4'(LOSS_THRESH);
  localparam logic [ACQ_W-1:0] ACQ_LAST = 5'd15;

  state_e              state_q, state_d;
  logic [LFSR_W-1:0]   s_q, s_d;
  logic [ACQ_W-1:0]    acq_cnt_q, acq_cnt_d;
  logic [3:0]          consec_q, consec_d;
  logic                locked_q, locked_d;
  logic                err_pulse_q, err_pulse_d;

  logic                accept_s;
  logic                exp_bit_s;
  logic                mis_s;
  logic [LFSR_W-1:0]   acq_s_s;
  logic [3:0]          consec_inc_s;

  assign accept_s     = ena & bit_valid;
  assign exp_bit_s    = lfsr_fb(s_q);
  assign acq_s_s      = {s_q[LFSR_W-2:0], bit_in};
  assign consec_inc_s = consec_q + 4'd1;

  // Next-state logic: acquisition shift-in, locked prediction and loss of lock.
  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    acq_cnt_d = acq_cnt_q;
    consec_d  = consec_q;
    mis_s     = 1'b0;
    if (accept_s) begin
      case (state_q)
        ST_ACQUIRE: begin
          s_d = acq_s_s;
          if (acq_cnt_q == ACQ_LAST) begin
            acq_cnt_d = 5'd0;
            // All-zero is the LFSR lock-up state; keep acquiring instead.
            if (acq_s_s != 16'h0000) begin
              state_d = ST_LOCKED;
            end else begin
              state_d = ST_ACQUIRE;
            end
          end else begin
            acq_cnt_d = acq_cnt_q + 5'd1;
          end
        end
        ST_LOCKED: begin
          s_d   = {s_q[LFSR_W-2:0], exp_bit_s};
          mis_s = bit_in ^ exp_bit_s;
          if (mis_s) begin
            if (consec_inc_s >= THRESH) begin
              state_d   = ST_ACQUIRE;
              acq_cnt_d = 5'd0;
              consec_d  = 4'd0;
            end else begin
              consec_d  = consec_inc_s;
            end
          end else begin
            consec_d = 4'd0;
          end
        end
        default: begin
          state_d   = ST_ACQUIRE;
          acq_cnt_d = 5'd0;
          consec_d  = 4'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Registered status outputs derived from the next state.
  always_comb begin
    locked_d    = (state_d == ST_LOCKED);
    err_pulse_d = mis_s;
  end

  // State, shift register, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACQUIRE;
      s_q         <= 16'h0000;
      acq_cnt_q   <= 5'd0;
      consec_q    <= 4'd0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      acq_cnt_q   <= acq_cnt_d;
      consec_q    <= consec_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  // Error counter: clear works regardless of ena.
  prng_err_counter #(
    .CNT_W (CNT_W)
  ) u_err_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (clr_cnt),
    .inc_i   (mis_s),
    .count_o (err_count)
  );

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;

endmodule
